// File: rtl/key_pkg.sv
// Shared constants and width helpers for the front-panel key conditioner.
package key_pkg;

  // Default timing for a 100 MHz system clock with a 1 us time-base tick.
  localparam int TICK_1US_100M = 100;     // clk cycles per 1 us tick
  localparam int DB_0P5MS      = 500;     // 0.5 ms debounce window in ticks
  localparam int LONG_1S       = 1000000; // 1 s long-press threshold in ticks
  localparam int REP_200MS     = 200000;  // 200 ms auto-repeat period in ticks

  // Bits needed to hold values 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    cnt_width = (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF sync, debounce on the shared tick, press/release
// edge pulses, and hold counter with long-press and auto-repeat pulses.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int ACTIVE_LOW = 1,
  parameter int DB_TICKS   = 4,
  parameter int LONG_TICKS = 20,
  parameter int REP_TICKS  = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic key_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int DBW = cnt_width(DB_TICKS);
  localparam int HW  = cnt_width(LONG_TICKS + REP_TICKS);

  localparam logic           IDLE     = (ACTIVE_LOW != 0);
  localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_TICKS - 1);
  localparam logic [HW-1:0]  LONG_C   = HW'(LONG_TICKS);
  // Top of the repeat window; the counter reloads to LONG+1 from here so
  // it never revisits LONG_TICKS and key_long cannot fire twice.
  localparam logic [HW-1:0]  TOP_C    = HW'(LONG_TICKS + REP_TICKS);
  localparam logic [HW-1:0]  RELOAD_C = HW'(LONG_TICKS + 1);

  logic           sync1_q, sync2_q;
  logic           level_q, level_d;
  logic           level_d1_q;
  logic [DBW-1:0] db_q, db_d;
  logic [HW-1:0]  hold_q, hold_d;
  // step_q marks the cycle right after the hold counter advanced, so each
  // threshold pulse fires once even when ticks are many clocks apart.
  logic           step_q, step_d;
  logic           press_q, press_d;
  logic           release_q, release_d;
  logic           long_q, long_d;
  logic           repeat_q, repeat_d;
  logic           pressed;
  logic           inc;

  assign pressed = (level_q != IDLE);

  // Debounce: any agreement clears the count at once; a disagreement must
  // persist for DB_TICKS consecutive ticks before the level is accepted.
  always_comb begin
    db_d    = db_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      db_d = '0;
    end else if (tick_i) begin
      if (db_q == DB_LAST) begin
        level_d = sync2_q;
        db_d    = '0;
      end else begin
        db_d = db_q + DBW'(1);
      end
    end
  end

  // Hold counter and registered pulse generation; every pulse is gated by
  // the current pressed state so nothing fires once the release is seen.
  always_comb begin
    hold_d    = hold_q;
    step_d    = 1'b0;
    inc       = tick_i && pressed && !((REP_TICKS == 0) && (hold_q == LONG_C));
    if (!pressed) begin
      hold_d = '0;
    end else if (inc) begin
      step_d = 1'b1;
      if ((REP_TICKS > 0) && (hold_q == TOP_C)) begin
        hold_d = RELOAD_C;
      end else begin
        hold_d = hold_q + HW'(1);
      end
    end
    press_d   = pressed && (level_d1_q == IDLE);
    release_d = !pressed && (level_d1_q != IDLE);
    long_d    = pressed && step_q && (hold_q == LONG_C);
    repeat_d  = (REP_TICKS > 0) && pressed && step_q && (hold_q == TOP_C);
  end

  // State registers; reset lands on the idle level so release is quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= IDLE;
      sync2_q    <= IDLE;
      level_q    <= IDLE;
      level_d1_q <= IDLE;
      db_q       <= '0;
      hold_q     <= '0;
      step_q     <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
    end else begin
      sync1_q    <= key_i;
      sync2_q    <= sync1_q;
      level_q    <= level_d;
      level_d1_q <= level_q;
      db_q       <= db_d;
      hold_q     <= hold_d;
      step_q     <= step_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_debounce_multi.sv
// Multi-channel front-panel key conditioner: shared tick prescaler, CH
// independent debounce channels, and a registered any-key-held flag.
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int CH         = 4,
  parameter int ACTIVE_LOW = 1,
  parameter int TICK_DIV   = TICK_1US_100M,
  parameter int DB_TICKS   = DB_0P5MS,
  parameter int LONG_TICKS = LONG_1S,
  parameter int REP_TICKS  = REP_200MS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] key_in,
  output logic [CH-1:0] key_level,
  output logic [CH-1:0] key_press,
  output logic [CH-1:0] key_release,
  output logic [CH-1:0] key_long,
  output logic [CH-1:0] key_repeat,
  output logic          key_held_any
);

  localparam int            PW      = cnt_width(TICK_DIV);
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] ps_q, ps_d;
  logic          tick;
  logic [CH-1:0] pressed_vec;
  logic          held_q;

  // With TICK_DIV = 1 the counter sits at zero and tick is constantly high.
  assign tick = (ps_q == PS_LAST);

  // Prescaler next state: wrap on the tick cycle.
  always_comb begin
    ps_d = tick ? '0 : ps_q + PW'(1);
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ps_q <= '0;
    else        ps_q <= ps_d;
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    key_debounce_ch #(
      .ACTIVE_LOW (ACTIVE_LOW),
      .DB_TICKS   (DB_TICKS),
      .LONG_TICKS (LONG_TICKS),
      .REP_TICKS  (REP_TICKS)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick_i    (tick),
      .key_i     (key_in[g]),
      .level_o   (key_level[g]),
      .press_o   (key_press[g]),
      .release_o (key_release[g]),
      .long_o    (key_long[g]),
      .repeat_o  (key_repeat[g])
    );
  end

  assign pressed_vec = (ACTIVE_LOW != 0) ? ~key_level : key_level;

  // Any-key-held flag, registered one clock behind the debounced levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) held_q <= 1'b0;
    else        held_q <= |pressed_vec;
  end

  assign key_held_any = held_q;

endmodule
